// File: rtl/fir_seq_pkg.sv
// Shared types and helpers for the serial FIR MAC sequencer.
// Saturation helper works on a wide accumulator and returns up to 64 bits.
package fir_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    SAT,
    OUT
  } state_t;

  localparam int SAT_IN_W  = 128;
  localparam int SAT_OUT_W = 64;

  function automatic int acc_width(
    input int width,
    input int coef_w,
    input int ncoefs
  );
    return width + coef_w + $clog2(ncoefs);
  endfunction

  function automatic logic [SAT_OUT_W-1:0] sat_shift(
    input logic signed [SAT_IN_W-1:0] acc,
    input int                         frac,
    input int                         width
  );
    logic signed [SAT_IN_W-1:0] sh;
    logic signed [SAT_IN_W-1:0] hi;
    logic signed [SAT_IN_W-1:0] lo;
    sh = acc >>> frac;
    hi = (128'sd1 <<< (width - 1)) - 128'sd1;
    lo = ~hi;
    if (sh > hi)
      return hi[SAT_OUT_W-1:0];
    else if (sh < lo)
      return lo[SAT_OUT_W-1:0];
    else
      return sh[SAT_OUT_W-1:0];
  endfunction

endpackage

// File: rtl/fir_mac_sequencer_mac.sv
// Signed multiply-accumulate with synchronous clear and enable.
// Clear wins over enable so a new sample always starts from zero.
module fir_mac_unit #(
  parameter int WIDTH  = 32,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 53
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     en,
  input  logic signed [WIDTH-1:0]  a,
  input  logic signed [COEF_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  localparam int PROD_W = WIDTH + COEF_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  acc_q;

  always_comb begin
    prod  = PROD_W'(a) * PROD_W'(b);
    acc_d = acc_q;
    if (clear)
      acc_d = '0;
    else if (en)
      acc_d = acc_q + ACC_W'(prod);
  end

  always_ff @(posedge clock) begin
    if (reset)
      acc_q <= '0;
    else
      acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/fir_mac_sequencer.sv
// Serial FIR: circular sample buffer, writable coefficient bank and
// one shared multiplier stepped through every tap per input sample.
module fir_mac_sequencer
  import fir_seq_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NCOEFS = 29,
  parameter int COEF_W = 16,
  parameter int FRAC   = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          xn,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          yn,
  input  logic                      cfg_we,
  input  logic [$clog2(NCOEFS)-1:0] cfg_addr,
  input  logic [COEF_W-1:0]         cfg_data,
  input  logic                      flush,
  output logic                      busy
);

  localparam int PTR_W = $clog2(NCOEFS);
  localparam int ACC_W = acc_width(WIDTH, COEF_W, NCOEFS);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NCOEFS - 1);
  localparam logic [PTR_W:0]   N_EXT = (PTR_W + 1)'(NCOEFS);

  state_t                   state_q, state_d;
  logic [PTR_W-1:0]         tap_q, tap_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic                     out_valid_q, out_valid_d;
  logic [WIDTH-1:0]         yn_q, yn_d;
  logic signed [WIDTH-1:0]  smp_q [NCOEFS];
  logic signed [WIDTH-1:0]  smp_d [NCOEFS];
  logic signed [COEF_W-1:0] coef_q [NCOEFS];
  logic signed [COEF_W-1:0] coef_d [NCOEFS];

  logic                     accept;
  logic [PTR_W-1:0]         rd_idx;
  logic signed [ACC_W-1:0]  acc;

  assign in_ready  = (state_q == IDLE) && !cfg_we && !flush;
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign yn        = yn_q;

  // Newest sample pairs with tap 0; wrap without assuming a power of two.
  always_comb begin
    if (tap_q > wr_ptr_q)
      rd_idx = PTR_W'({1'b0, wr_ptr_q} + N_EXT - {1'b0, tap_q});
    else
      rd_idx = wr_ptr_q - tap_q;
  end

  fir_mac_unit #(
    .WIDTH (WIDTH),
    .COEF_W(COEF_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clock(clock),
    .reset(reset),
    .clear(accept),
    .en   (state_q == MAC),
    .a    (smp_q[rd_idx]),
    .b    (coef_q[tap_q]),
    .acc  (acc)
  );

  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    wr_ptr_d    = wr_ptr_q;
    out_valid_d = out_valid_q;
    yn_d        = yn_q;
    smp_d       = smp_q;
    coef_d      = coef_q;
    case (state_q)
      IDLE: begin
        if (cfg_we && (int'(cfg_addr) < NCOEFS))
          coef_d[cfg_addr] = cfg_data;
        if (flush) begin
          for (int i = 0; i < NCOEFS; i++)
            smp_d[i] = '0;
          wr_ptr_d = '0;
        end
        if (accept) begin
          smp_d[wr_ptr_q] = xn;
          tap_d           = '0;
          state_d         = MAC;
        end
      end
      MAC: begin
        if (tap_q == LAST) begin
          tap_d   = '0;
          state_d = SAT;
        end else begin
          tap_d = tap_q + 1'b1;
        end
      end
      SAT: begin
        yn_d        = WIDTH'(sat_shift(SAT_IN_W'(acc), FRAC, WIDTH));
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          wr_ptr_d    = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      tap_q       <= '0;
      wr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      yn_q        <= '0;
      for (int i = 0; i < NCOEFS; i++) begin
        smp_q[i]  <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      wr_ptr_q    <= wr_ptr_d;
      out_valid_q <= out_valid_d;
      yn_q        <= yn_d;
      smp_q       <= smp_d;
      coef_q      <= coef_d;
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer at default parameters.
// Expected outputs are hand-computed from the Q8 filter definition.
module tb_fir_mac_sequencer;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] xn;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] yn;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        flush;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  logic [31:0] y;
  logic [31:0] y0;
  int lat;

  fir_mac_sequencer dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .xn       (xn),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .yn       (yn),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .flush    (flush),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write_coef(input int addr, input logic [15:0] data);
    cfg_we   = 1'b1;
    cfg_addr = 5'(addr);
    cfg_data = data;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic load_all(input logic [15:0] data);
    for (int k = 0; k < 29; k++)
      write_coef(k, data);
  endtask

  task automatic load_ramp();
    for (int k = 0; k < 29; k++)
      write_coef(k, 16'(k + 1));
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (out_valid !== 1'b1)
      check("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic run_sample(input logic [31:0] x, output logic [31:0] yo,
                            output int n);
    in_valid = 1'b1;
    xn       = x;
    tick();
    in_valid = 1'b0;
    xn       = '0;
    wait_valid(n);
    yo = yn;
    tick();
  endtask

  task automatic run_impulse();
    for (int n = 0; n < 29; n++) begin
      run_sample((n == 0) ? 32'd256 : 32'd0, y, lat);
      check("impulse_yn", y, 32'(n + 1));
      if (n == 0)
        check("impulse_latency", 32'(lat), 32'd30);
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    xn        = '0;
    out_ready = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    flush     = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_yn", yn, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Impulse through a ramp kernel
    load_ramp();
    run_impulse();

    // Step response across the write-pointer wrap
    load_all(16'd256);
    do_flush();
    for (int n = 0; n < 40; n++) begin
      run_sample(32'd100, y, lat);
      check("step_yn", y, (n < 29) ? 32'((n + 1) * 100) : 32'd2900);
    end

    // Saturation both ways, plus floor rounding of a small negative
    load_all(16'h7FFF);
    for (int n = 0; n < 3; n++) begin
      run_sample(32'h7FFF_FFFF, y, lat);
      check("sat_pos", y, 32'h7FFF_FFFF);
    end
    do_flush();
    run_sample(32'h8000_0000, y, lat);
    check("sat_neg", y, 32'h8000_0000);
    do_flush();
    run_sample(32'hFFFF_FFFF, y, lat);
    check("neg_floor", y, 32'hFFFF_FF80);

    // cfg_we during MAC must be ignored
    load_all(16'd256);
    do_flush();
    in_valid = 1'b1;
    xn       = 32'd100;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    cfg_we   = 1'b1;
    cfg_addr = 5'd0;
    cfg_data = 16'd512;
    tick();
    cfg_we = 1'b0;
    wait_valid(lat);
    check("cfg_mac_yn", yn, 32'd100);
    tick();
    do_flush();
    run_sample(32'd100, y, lat);
    check("cfg_mac_coef_kept", y, 32'd100);

    // cfg_we wins over in_valid in IDLE
    cfg_we   = 1'b1;
    cfg_addr = 5'd0;
    cfg_data = 16'd512;
    in_valid = 1'b1;
    xn       = 32'd100;
    #1;
    check("cfg_prio_in_ready", 32'(in_ready), 32'd0);
    tick();
    cfg_we = 1'b0;
    check("cfg_prio_not_accepted", 32'(busy), 32'd0);
    run_sample(32'd100, y, lat);
    check("cfg_prio_write_done", y, 32'd300);

    // flush clears history
    write_coef(0, 16'd256);
    do_flush();
    for (int n = 0; n < 5; n++) begin
      run_sample(32'd100, y, lat);
      check("pre_flush_yn", y, 32'((n + 1) * 100));
    end
    do_flush();
    run_sample(32'd100, y, lat);
    check("post_flush_yn", y, 32'd100);

    // Backpressure with in_valid held high
    do_flush();
    in_valid  = 1'b1;
    xn        = 32'd100;
    tick();
    xn        = 32'd999;
    out_ready = 1'b0;
    wait_valid(lat);
    y0 = yn;
    check("bp_first_yn", y0, 32'd100);
    for (int n = 0; n < 5; n++) begin
      tick();
      check("bp_yn_stable", yn, 32'd100);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_idle_busy", 32'(busy), 32'd0);
    check("bp_idle_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("bp_next_accepted", 32'(busy), 32'd1);
    in_valid = 1'b0;
    xn       = '0;
    wait_valid(lat);
    check("bp_second_yn", yn, 32'd1099);
    tick();

    // Reset in the middle of MAC
    in_valid = 1'b1;
    xn       = 32'd256;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    check("mid_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_yn", yn, 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    load_ramp();
    run_impulse();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
Time-multiplexed controller for a serial (single-multiplier) FIR, sharing the same filter function as gaussian_fir.
- Accepts one sample per handshake and stores it in a circular sample buffer.
- Steps one multiplier through NCOEFS taps and returns one filtered output per input sample.
- Coefficients live in a writable register bank (Q-format, FRAC fractional bits), so Gaussian or other kernels are loaded at run time.
- Sits between the sample source and the consumer, in place of the fully parallel FIR, where area matters more than throughput.

Parameters:
- WIDTH, 32, sample and output width; signed two's complement.
- NCOEFS, 29, number of taps and sample-buffer depth.
- COEF_W, 16, coefficient width; signed.
- FRAC, 8, coefficient fractional bits; the accumulator is shifted right by FRAC before saturation.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous active-high reset.
- in_valid  in  1  xn is valid.
- in_ready  out  1  block accepts xn this cycle.
- xn  in  WIDTH  input sample.
- out_valid  out  1  yn is valid.
- out_ready  in  1  consumer accepts yn.
- yn  out  WIDTH  filtered output, saturated.
- cfg_we  in  1  coefficient write strobe.
- cfg_addr  in  $clog2(NCOEFS)  coefficient index.
- cfg_data  in  COEF_W  coefficient value.
- flush  in  1  clears the sample buffer.
- busy  out  1  state is not IDLE.

Behaviour:
- Clock and reset: one clock, `clock`. Reset `reset` is synchronous and active-high; it is sampled only on the rising edge of `clock`.
- Reset values:
  - state=IDLE; in_ready=1; out_valid=0; yn=0; busy=0.
  - acc=0, tap=0, wr_ptr=0.
  - All sample-buffer entries and all coefficients = 0.
- Reset during MAC or OUT aborts the operation with no output; all registers take their reset values.
- State IDLE:
  - in_ready = !cfg_we && !flush.
  - On in_valid && in_ready: buf[wr_ptr] <= xn; acc <= 0; tap <= 0; go to MAC.
- State MAC, one tap per cycle:
  - acc <= acc + coef[tap] * buf[(wr_ptr - tap) mod NCOEFS]; tap <= tap + 1.
  - When tap == NCOEFS-1, go to SAT.
  - in_ready = 0.
- State SAT:
  - yn <= sat_WIDTH(acc >>> FRAC), using an arithmetic shift (truncation toward -inf).
  - out_valid <= 1; go to OUT.
- State OUT:
  - yn and out_valid are held stable until out_ready is high.
  - On out_ready: out_valid <= 0; wr_ptr <= (wr_ptr == NCOEFS-1) ? 0 : wr_ptr + 1; go to IDLE.
- Latency:
  - Accepting edge = edge 0; out_valid rises after edge NCOEFS+1 (edge 30 at defaults).
  - Minimum spacing between accepted samples = NCOEFS+3 cycles when out_ready is held high.
- Widths:
  - Product = WIDTH+COEF_W bits.
  - ACC_W = WIDTH+COEF_W+$clog2(NCOEFS); the accumulator never overflows.
  - Saturation: values > 2^(WIDTH-1)-1 clamp to 0x7FFF…F; values < -2^(WIDTH-1) clamp to 0x800…0.
- Coefficient writes:
  - Accepted only in IDLE; in that cycle cfg_we has priority over in_valid.
  - cfg_we outside IDLE is ignored.
  - cfg_addr >= NCOEFS is ignored.
- Flush:
  - In IDLE: zeroes all buffer entries and sets wr_ptr = 0; coefficients are untouched.
  - Outside IDLE: ignored.
  - flush has priority over in_valid.
- Buffer wrap: wr_ptr wraps NCOEFS-1 → 0. The read index is computed modulo NCOEFS without a power-of-2 assumption.

Decomposition:
- Package fir_seq_pkg:
  - state_t enum {IDLE, MAC, SAT, OUT}.
  - function acc_width(WIDTH, COEF_W, NCOEFS).
  - function sat_shift(acc, FRAC) returning WIDTH bits.
- Sub-module fir_mac_unit: signed multiply-accumulate with clear and enable, parameterised on WIDTH, COEF_W, ACC_W. The sequencer owns the FSM, the buffer and the coefficient bank.

Test Plan:
- Impulse:
  - Stimulus: coef[k]=k+1; xn=256, then 28 zeros, out_ready=1.
  - Required: yn sequence = 1, 2, …, 29.
  - Required: first out_valid exactly 30 cycles after the accept edge.
- Step and wrap:
  - Stimulus: all coef=256 (1.0); xn=100 repeated 40 times.
  - Required: yn = 100, 200, …, 2900, then 2900 steady across the wr_ptr wrap.
- Saturation:
  - Stimulus: all coef=0x7FFF; xn=0x7FFFFFFF repeated.
  - Required: yn=0x7FFFFFFF.
  - Stimulus: same coefficients with xn=0x80000000.
  - Required: yn=0x80000000.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles while in OUT, with in_valid held high.
  - Required: yn stable, out_valid=1, in_ready=0; the next sample is accepted only after the out_ready handshake and IDLE.
- Config and flush gating:
  - Stimulus: cfg_we during MAC.
  - Required: coefficient unchanged.
  - Stimulus: cfg_we and in_valid together in IDLE.
  - Required: write done, sample not accepted that cycle.
  - Stimulus: flush after 5 samples of 100 with all coef=256, then xn=100.
  - Required: yn=100.
- Reset mid-operation:
  - Stimulus: reset asserted at MAC tap 10.
  - Required: next edge gives out_valid=0, yn=0, busy=0; a following impulse with re-loaded coefficients matches the Impulse scenario.
